// File: rtl/svf_coeff_ctrl.sv
// svf_coeff_ctrl: register-programmed alpha1/alpha2/mode/route/volume
// writer for the 8-bit SVF; every change is applied on sample_valid.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   reg_we         register write strobe
//   reg_addr       0=FC_LO 1=FC_HI 2=RES_FILT 3=MODE_VOL
//   reg_wdata      write data
//   sample_valid   sample tick shared with the filter
//   alpha1         cutoff coefficient (11 bit)
//   alpha2         damping coefficient (2 bit, never 0)
//   filt_route     voice routing bits
//   mode           {HP,BP,LP} enables
//   volume         master volume
//   busy           alpha1 has not yet reached the committed target
//   coeff_upd      pulse marking an apply that changed an output
//
// Build option: define SVF_COEFF_SLEW_EN to slew alpha1 toward the
// target by at most SLEW_STEP per sample; otherwise alpha1 jumps.
module svf_coeff_ctrl #(
   parameter logic [10:0] SLEW_STEP = 11'd16,
   parameter logic [10:0] RESET_FC  = 11'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_we,
   input  logic [1:0]  reg_addr,
   input  logic [7:0]  reg_wdata,
   input  logic        sample_valid,
   output logic [10:0] alpha1,
   output logic [1:0]  alpha2,
   output logic [3:0]  filt_route,
   output logic [2:0]  mode,
   output logic [3:0]  volume,
   output logic        busy,
   output logic        coeff_upd
);

   logic [2:0]  fc_lo_shadow;
   logic [10:0] target;
   logic [3:0]  res_p;
   logic [3:0]  route_p;
   logic [2:0]  mode_p;
   logic [3:0]  vol_p;

   logic [10:0] a1_nxt;
   logic [1:0]  a2_nxt;
   logic        changed;

`ifdef SVF_COEFF_SLEW_EN
   logic signed [11:0] d;
   logic [11:0]        mag;

   // Slew never overshoots: a full step is only taken when the
   // remaining distance exceeds it, so alpha1 stays in 0..2047.
   always_comb begin
      d      = $signed({1'b0, target}) - $signed({1'b0, alpha1});
      mag    = d[11] ? 12'(-d) : 12'(d);
      a1_nxt = target;
      if (SLEW_STEP != 11'd0 && mag > {1'b0, SLEW_STEP}) begin
         if (d[11])
            a1_nxt = alpha1 - SLEW_STEP;
         else
            a1_nxt = alpha1 + SLEW_STEP;
      end
   end
`else
   logic unused_step;
   assign unused_step = ^SLEW_STEP;

   always_comb begin
      a1_nxt = target;
   end
`endif

   // Damping map keeps alpha2 nonzero for every resonance setting.
   always_comb begin
      a2_nxt = 2'd3;
      unique case (res_p[3:2])
         2'd0: a2_nxt = 2'd3;
         2'd1: a2_nxt = 2'd2;
         2'd2: a2_nxt = 2'd1;
         2'd3: a2_nxt = 2'd1;
      endcase
   end

   always_comb begin
      changed = (a1_nxt != alpha1)
              | (a2_nxt != alpha2)
              | (route_p != filt_route)
              | (mode_p != mode)
              | (vol_p != volume);
   end

   assign busy = (alpha1 != target);

   // Apply reads the pre-write pending values; a write in the same
   // cycle lands in the pending registers for the next sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         fc_lo_shadow <= 3'd0;
         target       <= RESET_FC;
         res_p        <= 4'd0;
         route_p      <= 4'd0;
         mode_p       <= 3'd0;
         vol_p        <= 4'd0;
         alpha1       <= RESET_FC;
         alpha2       <= 2'd3;
         filt_route   <= 4'd0;
         mode         <= 3'd0;
         volume       <= 4'd0;
         coeff_upd    <= 1'b0;
      end else begin
         coeff_upd <= 1'b0;
         if (sample_valid) begin
            alpha1     <= a1_nxt;
            alpha2     <= a2_nxt;
            filt_route <= route_p;
            mode       <= mode_p;
            volume     <= vol_p;
            coeff_upd  <= changed;
         end
         if (reg_we) begin
            unique case (reg_addr)
               2'd0: fc_lo_shadow <= reg_wdata[2:0];
               2'd1: target <= {reg_wdata, fc_lo_shadow};
               2'd2: begin
                  res_p   <= reg_wdata[7:4];
                  route_p <= reg_wdata[3:0];
               end
               2'd3: begin
                  mode_p <= reg_wdata[6:4];
                  vol_p  <= reg_wdata[3:0];
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_svf_coeff_ctrl.sv
// tb_svf_coeff_ctrl: directed checks of svf_coeff_ctrl register
// capture, sample-aligned apply, slew/jump and reset behaviour.
module tb_svf_coeff_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        sample_valid;
   logic [10:0] alpha1;
   logic [1:0]  alpha2;
   logic [3:0]  filt_route;
   logic [2:0]  mode;
   logic [3:0]  volume;
   logic        busy;
   logic        coeff_upd;

   int total = 0;
   int bad   = 0;

   svf_coeff_ctrl #(
      .SLEW_STEP (11'd16),
      .RESET_FC  (11'd0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .sample_valid (sample_valid),
      .alpha1       (alpha1),
      .alpha2       (alpha2),
      .filt_route   (filt_route),
      .mode         (mode),
      .volume       (volume),
      .busy         (busy),
      .coeff_upd    (coeff_upd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v,
                     input logic sv);
      reg_we       = 1'b1;
      reg_addr     = a;
      reg_wdata    = v;
      sample_valid = sv;
      cyc();
      reg_we       = 1'b0;
      sample_valid = 1'b0;
   endtask

   task automatic pulse();
      sample_valid = 1'b1;
      cyc();
      sample_valid = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      reg_we       = 1'b0;
      reg_addr     = 2'd0;
      reg_wdata    = 8'd0;
      sample_valid = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      chk("rst_alpha1", 32'(alpha1), 0);
      chk("rst_alpha2", 32'(alpha2), 3);
      chk("rst_route", 32'(filt_route), 0);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_volume", 32'(volume), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_upd", 32'(coeff_upd), 0);

      for (int i = 0; i < 2; i++) begin
         pulse();
         chk("idle_alpha1", 32'(alpha1), 0);
         chk("idle_alpha2", 32'(alpha2), 3);
         chk("idle_upd", 32'(coeff_upd), 0);
         chk("idle_busy", 32'(busy), 0);
      end

      // target = {0x40, 3'b101} = 0x205 = 517
      wr(2'd0, 8'h05, 1'b0);
      chk("lo_no_busy", 32'(busy), 0);
      wr(2'd1, 8'h40, 1'b0);
      chk("hi_busy", 32'(busy), 1);
      chk("hi_hold", 32'(alpha1), 0);
`ifdef SVF_COEFF_SLEW_EN
      for (int k = 1; k <= 33; k++) begin
         pulse();
         chk("slew_up", 32'(alpha1), (16 * k < 517) ? 16 * k : 517);
         chk("slew_busy", 32'(busy), (k < 33) ? 1 : 0);
         chk("slew_upd", 32'(coeff_upd), 1);
      end
`else
      pulse();
      chk("jump_alpha1", 32'(alpha1), 32'h205);
      chk("jump_upd", 32'(coeff_upd), 1);
      chk("jump_busy", 32'(busy), 0);
`endif
      cyc();
      chk("upd_one_cycle", 32'(coeff_upd), 0);

      wr(2'd0, 8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         pulse();
         chk("lo_only_alpha1", 32'(alpha1), 32'h205);
         chk("lo_only_busy", 32'(busy), 0);
         chk("lo_only_upd", 32'(coeff_upd), 0);
      end

      wr(2'd2, 8'hF3, 1'b1);
      chk("res_same_a2", 32'(alpha2), 3);
      chk("res_same_route", 32'(filt_route), 0);
      chk("res_same_upd", 32'(coeff_upd), 0);
      pulse();
      chk("res_next_a2", 32'(alpha2), 1);
      chk("res_next_route", 32'(filt_route), 3);
      chk("res_next_upd", 32'(coeff_upd), 1);

      wr(2'd3, 8'h5A, 1'b1);
      chk("mv_same_mode", 32'(mode), 0);
      chk("mv_same_vol", 32'(volume), 0);
      chk("mv_same_upd", 32'(coeff_upd), 0);
      pulse();
      chk("mv_next_mode", 32'(mode), 5);
      chk("mv_next_vol", 32'(volume), 10);
      chk("mv_next_a2", 32'(alpha2), 1);
      chk("mv_next_route", 32'(filt_route), 3);
      chk("mv_next_upd", 32'(coeff_upd), 1);

      // Walls of the range: 2000, then 2047, then 0.
      wr(2'd0, 8'h00, 1'b0);
      wr(2'd1, 8'hFA, 1'b0);
`ifdef SVF_COEFF_SLEW_EN
      for (int k = 1; k <= 93; k++) pulse();
      chk("at_2000", 32'(alpha1), 2000);
      chk("at_2000_busy", 32'(busy), 0);
      wr(2'd0, 8'h07, 1'b0);
      wr(2'd1, 8'hFF, 1'b0);
      pulse();
      chk("top_1", 32'(alpha1), 2016);
      pulse();
      chk("top_2", 32'(alpha1), 2032);
      pulse();
      chk("top_clamp", 32'(alpha1), 2047);
      chk("top_busy", 32'(busy), 0);
      wr(2'd0, 8'h00, 1'b0);
      wr(2'd1, 8'h00, 1'b0);
      for (int k = 1; k <= 128; k++) begin
         pulse();
         chk("slew_down", 32'(alpha1),
             (k < 128) ? 2047 - 16 * k : 0);
      end
      chk("bottom_busy", 32'(busy), 0);
`else
      pulse();
      chk("at_2000", 32'(alpha1), 2000);
      wr(2'd0, 8'h07, 1'b0);
      wr(2'd1, 8'hFF, 1'b0);
      pulse();
      chk("top_clamp", 32'(alpha1), 2047);
      wr(2'd0, 8'h00, 1'b0);
      wr(2'd1, 8'h00, 1'b0);
      pulse();
      chk("bottom", 32'(alpha1), 0);
      chk("bottom_busy", 32'(busy), 0);
`endif

      // Reset with a target outstanding abandons it.
      wr(2'd1, 8'h80, 1'b0);
      pulse();
`ifdef SVF_COEFF_SLEW_EN
      chk("pre_rst_alpha1", 32'(alpha1), 16);
`else
      chk("pre_rst_alpha1", 32'(alpha1), 32'h400);
`endif
      wr(2'd1, 8'hFF, 1'b0);
      chk("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_alpha1", 32'(alpha1), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_a2", 32'(alpha2), 3);
      chk("mid_rst_mode", 32'(mode), 0);
      chk("mid_rst_vol", 32'(volume), 0);
      pulse();
      chk("post_rst_alpha1", 32'(alpha1), 0);
      chk("post_rst_upd", 32'(coeff_upd), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
